mileage_recorder: RTL and testbench

- Writer side of the 24-bit record bus that the team's seven-segment record display consumes.
- Accumulates travelled distance while the car is powered and moving.
- Presents distance as six packed BCD digits; record[23:20] is the most significant digit and record[3:0] the least.
- Sits between the drive-control FSM, which supplies power_now and moving, and the record display path.

---
 rtl/mileage_recorder.sv | 112 +++++++++++
 tb/tb_mileage_recorder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mileage_recorder.sv
// Odometer writer for the seven-segment record bus: counts powered, moving time
// in units of TICKS_PER_UNIT cycles and presents the total as six packed BCD digits.
module mileage_recorder #(
  parameter int unsigned TICKS_PER_UNIT = 100000000,
  parameter logic [23:0] MAX_BCD        = 24'h999999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        power_now,
  input  logic        moving,
  input  logic        clear,
  output logic [23:0] record,
  output logic        update,
  output logic        full
);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    IDLE  = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam logic [26:0] LAST_TICK = 27'(TICKS_PER_UNIT - 1);

  state_t      state, state_next;
  logic [26:0] prescaler, prescaler_next;
  logic [23:0] record_next;
  logic        update_next;
  logic        tick;
  logic        unit_done;

  // Full six-digit ripple in one cycle; a 9 rolls to 0 and passes the carry up.
  function automatic logic [23:0] bcd_inc(input logic [23:0] value);
    logic [23:0] result;
    logic        carry;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (value[4*i +: 4] == 4'd9) begin
          result[4*i +: 4] = 4'd0;
        end else begin
          result[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    return result;
  endfunction

  assign full      = (record == MAX_BCD);
  assign tick      = (state == COUNT) && moving;
  assign unit_done = tick && (prescaler == LAST_TICK);

  always_comb begin
    state_next = state;
    case (state)
      OFF: begin
        if (power_now) state_next = IDLE;
      end
      IDLE: begin
        if (!power_now)  state_next = OFF;
        else if (moving) state_next = COUNT;
      end
      COUNT: begin
        if (!power_now)   state_next = OFF;
        else if (!moving) state_next = IDLE;
      end
      default: state_next = OFF;
    endcase
  end

  // IDLE leaves the prescaler alone so a partial unit survives a stop while powered.
  always_comb begin
    prescaler_next = prescaler;
    if (clear || (state_next == OFF)) begin
      prescaler_next = 27'd0;
    end else if (unit_done) begin
      prescaler_next = 27'd0;
    end else if (tick) begin
      prescaler_next = prescaler + 27'd1;
    end
  end

  // Clear takes priority over a coincident increment; saturation drops increments silently.
  always_comb begin
    record_next = record;
    update_next = 1'b0;
    if (clear) begin
      record_next = 24'h000000;
      update_next = (record != 24'h000000);
    end else if (unit_done && !full) begin
      record_next = bcd_inc(record);
      update_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= OFF;
      prescaler <= 27'd0;
      record    <= 24'h000000;
      update    <= 1'b0;
    end else begin
      state     <= state_next;
      prescaler <= prescaler_next;
      record    <= record_next;
      update    <= update_next;
    end
  end

endmodule

// File: tb/tb_mileage_recorder.sv
// Directed bench for mileage_recorder: three instances cover the normal unit
// length, a short unit for BCD ripple runs, and a small saturation limit.
module tb_mileage_recorder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, power_a, moving_a, clear_a, update_a, full_a;
  logic        rst_b, power_b, moving_b, clear_b, update_b, full_b;
  logic        rst_c, power_c, moving_c, clear_c, update_c, full_c;
  logic [23:0] record_a, record_b, record_c;

  int assert_count = 0;
  int fail_count   = 0;
  logic bad_bcd_a = 1'b0;
  logic bad_bcd_b = 1'b0;

  mileage_recorder #(.TICKS_PER_UNIT(4), .MAX_BCD(24'h999999)) dut_a (
    .clk(clk), .rst(rst_a), .power_now(power_a), .moving(moving_a), .clear(clear_a),
    .record(record_a), .update(update_a), .full(full_a));

  mileage_recorder #(.TICKS_PER_UNIT(2), .MAX_BCD(24'h999999)) dut_b (
    .clk(clk), .rst(rst_b), .power_now(power_b), .moving(moving_b), .clear(clear_b),
    .record(record_b), .update(update_b), .full(full_b));

  mileage_recorder #(.TICKS_PER_UNIT(4), .MAX_BCD(24'h000012)) dut_c (
    .clk(clk), .rst(rst_c), .power_now(power_c), .moving(moving_c), .clear(clear_c),
    .record(record_c), .update(update_c), .full(full_c));

  // Flag any nibble above 9 ever seen on the counting instances.
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (record_a[4*i +: 4] > 4'd9) bad_bcd_a <= 1'b1;
      if (record_b[4*i +: 4] > 4'd9) bad_bcd_b <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [23:0] rec_of(input int which);
    case (which)
      0:       return record_a;
      1:       return record_b;
      default: return record_c;
    endcase
  endfunction

  function automatic logic upd_of(input int which);
    case (which)
      0:       return update_a;
      1:       return update_b;
      default: return update_c;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the number of negedges until update is seen, or -1 if the bound expires.
  task automatic wait_update(input int which, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (upd_of(which)) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic wait_record(input int which, input logic [23:0] target, input int limit,
                             output logic found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rec_of(which) == target) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int   cycles;
    int   pulses;
    logic found;
    logic exp_upd;
    logic [23:0] exp_rec;

    rst_a = 1'b0; power_a = 1'b0; moving_a = 1'b0; clear_a = 1'b0;
    rst_b = 1'b0; power_b = 1'b0; moving_b = 1'b0; clear_b = 1'b0;
    rst_c = 1'b0; power_c = 1'b0; moving_c = 1'b0; clear_c = 1'b0;

    #12;
    checkOutput("reset_record", 32'(record_a), 32'h0);
    checkOutput("reset_update", 32'(update_a), 32'h0);
    checkOutput("reset_full",   32'(full_a),   32'h0);
    checkOutput("reset_full_c", 32'(full_c),   32'h0);

    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    power_a = 1'b1; moving_a = 1'b1;

    // Basic count: increments land after edges 6, 10 and 14.
    pulses = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      exp_upd = (cyc >= 6) && (((cyc - 6) % 4) == 0);
      exp_rec = (cyc < 6) ? 24'h0 : 24'(1 + (cyc - 6) / 4);
      if (update_a) pulses++;
      checkOutput($sformatf("count_update_c%0d", cyc), 32'(update_a), 32'(exp_upd));
      checkOutput($sformatf("count_record_c%0d", cyc), 32'(record_a), 32'(exp_rec));
    end
    checkOutput("count_pulses", 32'(pulses), 32'd3);

    // Stop after two ticks; the held prescaler needs two more after re-entering COUNT.
    step(2);
    moving_a = 1'b0;
    step(3);
    checkOutput("stop_record", 32'(record_a), 32'h3);
    checkOutput("stop_update", 32'(update_a), 32'h0);
    moving_a = 1'b1;
    wait_update(0, 10, cycles);
    checkOutput("stop_latency", 32'(cycles), 32'd3);
    checkOutput("stop_record4", 32'(record_a), 32'h4);

    // Power loss keeps the record but discards the partial unit.
    step(2);
    power_a = 1'b0;
    step(2);
    checkOutput("off_record", 32'(record_a), 32'h4);
    checkOutput("off_update", 32'(update_a), 32'h0);
    power_a = 1'b1;
    wait_update(0, 20, cycles);
    checkOutput("power_latency", 32'(cycles), 32'd6);
    checkOutput("power_record5", 32'(record_a), 32'h5);

    // Clear on the exact increment edge.
    step(3);
    checkOutput("coll_pre_record", 32'(record_a), 32'h5);
    clear_a = 1'b1;
    step(1);
    clear_a = 1'b0;
    checkOutput("coll_record", 32'(record_a), 32'h0);
    checkOutput("coll_update", 32'(update_a), 32'h1);
    step(1);
    checkOutput("coll_update_drop", 32'(update_a), 32'h0);
    wait_update(0, 10, cycles);
    checkOutput("coll_prescaler", 32'(cycles), 32'd3);
    checkOutput("coll_next_record", 32'(record_a), 32'h1);

    // Clear while OFF, then clear of an already-zero record.
    power_a = 1'b0;
    step(1);
    clear_a = 1'b1;
    step(1);
    checkOutput("offclr_record", 32'(record_a), 32'h0);
    checkOutput("offclr_update", 32'(update_a), 32'h1);
    step(1);
    checkOutput("zeroclr_update", 32'(update_a), 32'h0);
    clear_a = 1'b0;

    // Count to 000123, then reset asynchronously while the update pulse is high.
    power_a = 1'b1;
    wait_record(0, 24'h000123, 1000, found);
    checkOutput("rst_reach_123", 32'(found), 32'h1);
    checkOutput("rst_pre_update", 32'(update_a), 32'h1);
    #2 rst_a = 1'b0;
    #1;
    checkOutput("rst_async_record", 32'(record_a), 32'h0);
    checkOutput("rst_async_update", 32'(update_a), 32'h0);
    checkOutput("rst_async_full",   32'(full_a),   32'h0);
    @(negedge clk);
    rst_a = 1'b1; power_a = 1'b0; moving_a = 1'b0;

    // BCD ripple with a two-cycle unit.
    power_b = 1'b1; moving_b = 1'b1;
    wait_record(1, 24'h000099, 400, found);
    checkOutput("ripple_reach_99", 32'(found), 32'h1);
    wait_update(1, 5, cycles);
    checkOutput("ripple_gap_99", 32'(cycles), 32'd2);
    checkOutput("ripple_100", 32'(record_b), 32'h000100);
    wait_record(1, 24'h009999, 25000, found);
    checkOutput("ripple_reach_9999", 32'(found), 32'h1);
    wait_update(1, 5, cycles);
    checkOutput("ripple_gap_9999", 32'(cycles), 32'd2);
    checkOutput("ripple_10000", 32'(record_b), 32'h010000);
    checkOutput("bcd_valid_b", 32'(bad_bcd_b), 32'h0);
    checkOutput("bcd_valid_a", 32'(bad_bcd_a), 32'h0);
    power_b = 1'b0; moving_b = 1'b0;

    // Saturation at 000012.
    power_c = 1'b1; moving_c = 1'b1;
    wait_record(2, 24'h000011, 200, found);
    checkOutput("sat_reach_11", 32'(found), 32'h1);
    checkOutput("sat_full_11", 32'(full_c), 32'h0);
    wait_update(2, 10, cycles);
    checkOutput("sat_record_12", 32'(record_c), 32'h000012);
    checkOutput("sat_full_12", 32'(full_c), 32'h1);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (update_c) pulses++;
    end
    checkOutput("sat_no_pulses", 32'(pulses), 32'd0);
    checkOutput("sat_hold", 32'(record_c), 32'h000012);
    clear_c = 1'b1;
    step(1);
    clear_c = 1'b0;
    checkOutput("sat_clr_record", 32'(record_c), 32'h0);
    checkOutput("sat_clr_full", 32'(full_c), 32'h0);
    checkOutput("sat_clr_update", 32'(update_c), 32'h1);
    step(1);
    checkOutput("sat_clr_update_drop", 32'(update_c), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
